quadrature_decoder_n: RTL and testbench

Parametrised successor of the single-wheel encoder interface. It synchronises and glitch-filters the A/B channels of one quadrature encoder and decodes them at x1, x2 or x4 resolution. It keeps a signed position counter that either wraps or saturates, flags illegal transitions, and reports steps per fixed time window as a velocity. It sits between the wheel encoder pins and the motion-control/display logic. One instance is used per wheel.

---
 rtl/quadrature_decoder_n_if.sv | 31 +++
 rtl/quadrature_decoder_n.sv | 179 +++++++++++++++++
 tb/tb_quadrature_decoder_n.sv | 233 +++++++++++++++++++++++
 3 files changed

// File: rtl/quadrature_decoder_n_if.sv
`default_nettype none
// +---------------------------------------------------------------------------
// | quadrature_decoder_n_if : encoder pins, clear and decoded outputs
// | Revision: 1.0
// +---------------------------------------------------------------------------
interface quadrature_decoder_n_if #(
   parameter int WIDTH = 16,
   parameter int VEL_W = 12
);
   logic             A;
   logic             B;
   logic             count_clr;
   logic [WIDTH-1:0] position;
   logic             step_cw;
   logic             step_ccw;
   logic             dir;
   logic             err;
   logic [VEL_W-1:0] velocity;
   logic             vel_valid;

   modport master (
      output A, B, count_clr,
      input  position, step_cw, step_ccw, dir, err, velocity, vel_valid
   );

   modport slave (
      input  A, B, count_clr,
      output position, step_cw, step_ccw, dir, err, velocity, vel_valid
   );
endinterface
`default_nettype wire

// File: rtl/quadrature_decoder_n.sv
`default_nettype none
// +---------------------------------------------------------------------------
// | quadrature_decoder_n : synchronised, filtered x1/x2/x4 quadrature decoder
// |                        with position counter and windowed velocity
// | Revision: 1.0
// +---------------------------------------------------------------------------
module quadrature_decoder_n #(
   parameter int WIDTH  = 16,
   parameter int MODE   = 4,
   parameter int FILT   = 3,
   parameter int WRAP   = 1,
   parameter int WINDOW = 1000,
   parameter int VEL_W  = 12
) (
   input  logic                  clk,
   input  logic                  reset_n,
   quadrature_decoder_n_if.slave bus
);
   localparam int                 c_win_w    = $clog2(WINDOW);
   localparam logic [c_win_w-1:0] c_win_last = c_win_w'(WINDOW - 1);
   localparam logic [WIDTH-1:0]   c_pos_max  = {1'b0, {(WIDTH-1){1'b1}}};
   localparam logic [WIDTH-1:0]   c_pos_min  = {1'b1, {(WIDTH-1){1'b0}}};
   localparam logic [VEL_W-1:0]   c_vel_max  = {1'b0, {(VEL_W-1){1'b1}}};
   localparam logic [VEL_W-1:0]   c_vel_min  = {1'b1, {(VEL_W-1){1'b0}}};

   // Bit 1 carries channel A, bit 0 channel B throughout.
   logic [1:0]         r_s1;
   logic [1:0]         r_s2;
   logic [1:0]         w_filt;
   logic [1:0]         r_prev;
   logic [3:0]         w_trans;
   logic               w_cw_any;
   logic               w_ccw_any;
   logic               w_up;
   logic               w_dn;
   logic               w_illegal;
   logic [WIDTH-1:0]   r_position;
   logic               r_step_cw;
   logic               r_step_ccw;
   logic               r_dir;
   logic               r_err;
   logic [VEL_W-1:0]   r_acc;
   logic [VEL_W-1:0]   w_acc_next;
   logic [VEL_W-1:0]   r_velocity;
   logic               r_vel_valid;
   logic [c_win_w-1:0] r_win;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_s1 <= 2'b00;
         r_s2 <= 2'b00;
      end else begin
         r_s1 <= {bus.A, bus.B};
         r_s2 <= r_s1;
      end
   end

   generate
      if (FILT == 0) begin : g_nofilt
         assign w_filt = r_s2;
      end else begin : g_filt
         localparam int c_cnt_w = $clog2(FILT + 1);
         for (genvar ch = 0; ch < 2; ch++) begin : g_ch
            logic [c_cnt_w-1:0] r_cnt;
            logic               r_f;
            // Any return to the filtered value restarts the stability count.
            always_ff @(posedge clk or negedge reset_n) begin
               if (!reset_n) begin
                  r_cnt <= '0;
                  r_f   <= 1'b0;
               end else if (r_s2[ch] == r_f) begin
                  r_cnt <= '0;
               end else if (r_cnt == c_cnt_w'(FILT - 1)) begin
                  r_cnt <= '0;
                  r_f   <= r_s2[ch];
               end else begin
                  r_cnt <= r_cnt + c_cnt_w'(1);
               end
            end
            assign w_filt[ch] = r_f;
         end
      end
   endgenerate

   assign w_trans   = {r_prev, w_filt};
   assign w_illegal = ((r_prev ^ w_filt) == 2'b11);

   always_comb begin
      w_cw_any  = 1'b0;
      w_ccw_any = 1'b0;
      case (w_trans)
         4'b0010, 4'b1011, 4'b1101, 4'b0100: w_cw_any  = 1'b1;
         4'b0001, 4'b0111, 4'b1110, 4'b1000: w_ccw_any = 1'b1;
         default: ;
      endcase
      w_up = 1'b0;
      w_dn = 1'b0;
      if (MODE == 1) begin
         w_up = (w_trans == 4'b0100);
         w_dn = (w_trans == 4'b0001);
      end else if (MODE == 2) begin
         w_up = w_cw_any  && (r_prev[1] != w_filt[1]);
         w_dn = w_ccw_any && (r_prev[1] != w_filt[1]);
      end else begin
         w_up = w_cw_any;
         w_dn = w_ccw_any;
      end
   end

   always_comb begin
      w_acc_next = r_acc;
      if (w_up && (r_acc != c_vel_max)) begin
         w_acc_next = r_acc + VEL_W'(1);
      end else if (w_dn && (r_acc != c_vel_min)) begin
         w_acc_next = r_acc - VEL_W'(1);
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_prev     <= 2'b00;
         r_position <= '0;
         r_step_cw  <= 1'b0;
         r_step_ccw <= 1'b0;
         r_dir      <= 1'b0;
         r_err      <= 1'b0;
      end else begin
         r_prev <= w_filt;
         if (bus.count_clr) begin
            r_position <= '0;
            r_step_cw  <= 1'b0;
            r_step_ccw <= 1'b0;
            r_err      <= 1'b0;
         end else begin
            r_step_cw  <= w_up;
            r_step_ccw <= w_dn;
            if (w_up) begin
               r_dir <= 1'b1;
               if ((WRAP != 0) || (r_position != c_pos_max)) r_position <= r_position + WIDTH'(1);
            end else if (w_dn) begin
               r_dir <= 1'b0;
               if ((WRAP != 0) || (r_position != c_pos_min)) r_position <= r_position - WIDTH'(1);
            end
            if (w_illegal) r_err <= 1'b1;
         end
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_acc       <= '0;
         r_velocity  <= '0;
         r_vel_valid <= 1'b0;
         r_win       <= '0;
      end else if (bus.count_clr) begin
         r_acc       <= '0;
         r_vel_valid <= 1'b0;
         r_win       <= '0;
      end else if (r_win == c_win_last) begin
         r_velocity  <= w_acc_next;
         r_vel_valid <= 1'b1;
         r_acc       <= '0;
         r_win       <= '0;
      end else begin
         r_acc       <= w_acc_next;
         r_vel_valid <= 1'b0;
         r_win       <= r_win + c_win_w'(1);
      end
   end

   assign bus.position  = r_position;
   assign bus.step_cw   = r_step_cw;
   assign bus.step_ccw  = r_step_ccw;
   assign bus.dir       = r_dir;
   assign bus.err       = r_err;
   assign bus.velocity  = r_velocity;
   assign bus.vel_valid = r_vel_valid;
endmodule
`default_nettype wire

// File: tb/tb_quadrature_decoder_n.sv
`default_nettype none
// Bench for quadrature_decoder_n: five parameter sets share one encoder stimulus;
// the x4 default instance is tracked by a step scoreboard with latency stamps.
module tb_quadrature_decoder_n;
   logic clk = 1'b0;
   logic reset_n;
   logic a, b, clr;
   int   cyc = 0;
   int   checks = 0;
   int   errors = 0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   quadrature_decoder_n_if #(.WIDTH(16), .VEL_W(12)) if_def ();
   quadrature_decoder_n_if #(.WIDTH(16), .VEL_W(12)) if_m1 ();
   quadrature_decoder_n_if #(.WIDTH(16), .VEL_W(12)) if_m2 ();
   quadrature_decoder_n_if #(.WIDTH(4),  .VEL_W(12)) if_wrap ();
   quadrature_decoder_n_if #(.WIDTH(4),  .VEL_W(12)) if_sat ();

   assign if_def.A  = a; assign if_def.B  = b; assign if_def.count_clr  = clr;
   assign if_m1.A   = a; assign if_m1.B   = b; assign if_m1.count_clr   = clr;
   assign if_m2.A   = a; assign if_m2.B   = b; assign if_m2.count_clr   = clr;
   assign if_wrap.A = a; assign if_wrap.B = b; assign if_wrap.count_clr = clr;
   assign if_sat.A  = a; assign if_sat.B  = b; assign if_sat.count_clr  = clr;

   quadrature_decoder_n #(.WIDTH(16), .MODE(4), .FILT(3), .WRAP(1), .WINDOW(100), .VEL_W(12))
      u_def  (.clk(clk), .reset_n(reset_n), .bus(if_def));
   quadrature_decoder_n #(.WIDTH(16), .MODE(1), .FILT(3), .WRAP(1), .WINDOW(100), .VEL_W(12))
      u_m1   (.clk(clk), .reset_n(reset_n), .bus(if_m1));
   quadrature_decoder_n #(.WIDTH(16), .MODE(2), .FILT(3), .WRAP(1), .WINDOW(100), .VEL_W(12))
      u_m2   (.clk(clk), .reset_n(reset_n), .bus(if_m2));
   quadrature_decoder_n #(.WIDTH(4),  .MODE(4), .FILT(3), .WRAP(1), .WINDOW(100), .VEL_W(12))
      u_wrap (.clk(clk), .reset_n(reset_n), .bus(if_wrap));
   quadrature_decoder_n #(.WIDTH(4),  .MODE(4), .FILT(3), .WRAP(0), .WINDOW(100), .VEL_W(12))
      u_sat  (.clk(clk), .reset_n(reset_n), .bus(if_sat));

   typedef struct { int pos; bit cw; int cyc; }         exp_t;
   typedef struct { int pos; bit cw; bit dir; int cyc; } obs_t;
   typedef struct {
      int steps; int p_def; int p_m1; int p_m2; int p_wrap; int p_sat;
      bit dir; int cw_def; int ccw_def; int cw_sat;
   } vec_t;

   exp_t exp_q[$];
   obs_t obs_q[$];
   int   obs_rd = 0;
   int   sat_cw = 0;
   int   idx = 0;
   int   model_pos = 0;

   always @(negedge clk) begin
      if (reset_n && (if_def.step_cw || if_def.step_ccw))
         obs_q.push_back('{pos: int'($signed(if_def.position)), cw: if_def.step_cw,
                           dir: if_def.dir, cyc: cyc});
      if (reset_n && if_sat.step_cw) sat_cw = sat_cw + 1;
   end

   function automatic logic [1:0] gray(input int i);
      case (i & 3)
         0: gray = 2'b00;
         1: gray = 2'b10;
         2: gray = 2'b11;
         default: gray = 2'b01;
      endcase
   endfunction

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // One quarter step every 10 clk; the x4 instance should report it 3+FILT=6 clk later.
   task automatic qstep(input int d, input bit push);
      @(negedge clk);
      idx = (idx + d) & 3;
      {a, b} = gray(idx);
      if (push) begin
         model_pos += d;
         exp_q.push_back('{pos: model_pos, cw: (d > 0), cyc: cyc + 6});
      end
      repeat (9) @(negedge clk);
   endtask

   task automatic drain();
      int n;
      repeat (12) @(negedge clk);
      chk("sb_count", obs_q.size() - obs_rd, exp_q.size());
      n = exp_q.size();
      if (obs_q.size() - obs_rd < n) n = obs_q.size() - obs_rd;
      for (int i = 0; i < n; i++) begin
         chk("sb_pos", obs_q[obs_rd + i].pos, exp_q[i].pos);
         chk("sb_pulse_dir", int'(obs_q[obs_rd + i].cw), int'(exp_q[i].cw));
         chk("sb_dir", int'(obs_q[obs_rd + i].dir), int'(exp_q[i].cw));
         chk("sb_latency", obs_q[obs_rd + i].cyc, exp_q[i].cyc);
      end
      exp_q.delete();
      obs_rd = obs_q.size();
   endtask

   task automatic vel_check(input int expv);
      int last;
      bit seen;
      last = 0;
      for (int k = 0; k < 4; k++) begin
         seen = 1'b0;
         for (int t = 0; t < 150 && !seen; t++) begin
            @(negedge clk);
            if (if_def.vel_valid) seen = 1'b1;
         end
         chk("vel_valid_seen", int'(seen), 1);
         if (!seen) break;
         if (k > 0) begin
            chk("vel_value", int'($signed(if_def.velocity)), expv);
            chk("vel_period", cyc - last, 100);
         end
         last = cyc;
      end
   endtask

   initial begin
      vec_t vt[3];
      int   row_start, cw_n, ccw_n, sat0;

      vt[0] = '{steps:   8, p_def:  8, p_m1: 2, p_m2:  4, p_wrap: -8, p_sat:  7,
                dir: 1, cw_def:  8, ccw_def:  0, cw_sat:  8};
      vt[1] = '{steps:  24, p_def: 32, p_m1: 8, p_m2: 16, p_wrap:  0, p_sat:  7,
                dir: 1, cw_def: 24, ccw_def:  0, cw_sat: 24};
      vt[2] = '{steps: -12, p_def: 20, p_m1: 5, p_m2: 10, p_wrap:  4, p_sat: -5,
                dir: 0, cw_def:  0, ccw_def: 12, cw_sat:  0};

      reset_n = 1'b0; a = 1'b0; b = 1'b0; clr = 1'b0;
      repeat (3) @(negedge clk);
      chk("rst_position", int'(if_def.position), 0);
      chk("rst_step_cw", int'(if_def.step_cw), 0);
      chk("rst_step_ccw", int'(if_def.step_ccw), 0);
      chk("rst_dir", int'(if_def.dir), 0);
      chk("rst_err", int'(if_def.err), 0);
      chk("rst_velocity", int'(if_def.velocity), 0);
      chk("rst_vel_valid", int'(if_def.vel_valid), 0);
      reset_n = 1'b1;
      repeat (3) @(negedge clk);

      for (int r = 0; r < 3; r++) begin
         row_start = obs_rd;
         sat0 = sat_cw;
         for (int j = 0; j < (vt[r].steps < 0 ? -vt[r].steps : vt[r].steps); j++)
            qstep(vt[r].steps < 0 ? -1 : 1, 1'b1);
         drain();
         cw_n = 0; ccw_n = 0;
         for (int i = row_start; i < obs_q.size(); i++)
            if (obs_q[i].cw) cw_n++; else ccw_n++;
         chk("vec_pos_x4", int'($signed(if_def.position)), vt[r].p_def);
         chk("vec_pos_x1", int'($signed(if_m1.position)), vt[r].p_m1);
         chk("vec_pos_x2", int'($signed(if_m2.position)), vt[r].p_m2);
         chk("vec_pos_wrap4", int'($signed(if_wrap.position)), vt[r].p_wrap);
         chk("vec_pos_sat4", int'($signed(if_sat.position)), vt[r].p_sat);
         chk("vec_dir", int'(if_def.dir), int'(vt[r].dir));
         chk("vec_err", int'(if_def.err), 0);
         chk("vec_cw_pulses", cw_n, vt[r].cw_def);
         chk("vec_ccw_pulses", ccw_n, vt[r].ccw_def);
         chk("vec_sat_cw_pulses", sat_cw - sat0, vt[r].cw_sat);
      end

      // Short A glitches at rest must be swallowed by the filter.
      for (int g = 0; g < 3; g++) begin
         @(negedge clk); a = 1'b1;
         repeat (2) @(negedge clk); a = 1'b0;
         repeat (4) @(negedge clk);
      end
      repeat (10) @(negedge clk);
      chk("glitch_pos", int'($signed(if_def.position)), model_pos);
      chk("glitch_err", int'(if_def.err), 0);
      qstep(1, 1'b1);
      qstep(-1, 1'b1);
      drain();

      // Both channels flip together: illegal, no count.
      @(negedge clk); a = 1'b1; b = 1'b1; idx = 2;
      repeat (12) @(negedge clk);
      chk("illegal_err", int'(if_def.err), 1);
      chk("illegal_pos", int'($signed(if_def.position)), model_pos);
      @(negedge clk); clr = 1'b1;
      @(negedge clk); clr = 1'b0;
      @(negedge clk);
      chk("clr_err", int'(if_def.err), 0);
      chk("clr_pos", int'($signed(if_def.position)), 0);
      model_pos = 0;

      // Step lands in the same cycle as the clear: discarded, no pulse.
      @(negedge clk); idx = 3; {a, b} = gray(idx);
      repeat (5) @(negedge clk); clr = 1'b1;
      @(negedge clk); clr = 1'b0;
      repeat (10) @(negedge clk);
      chk("clr_coinc_pos", int'($signed(if_def.position)), 0);
      drain();

      fork
         for (int j = 0; j < 60; j++) qstep(1, 1'b1);
         vel_check(10);
      join
      drain();
      fork
         for (int j = 0; j < 60; j++) qstep(-1, 1'b1);
         vel_check(-10);
      join
      drain();
      qstep(1, 1'b1);
      drain();

      repeat (37) @(negedge clk);
      #2 reset_n = 1'b0;
      #1;
      chk("midrst_position", int'(if_def.position), 0);
      chk("midrst_step_cw", int'(if_def.step_cw), 0);
      chk("midrst_step_ccw", int'(if_def.step_ccw), 0);
      chk("midrst_dir", int'(if_def.dir), 0);
      chk("midrst_err", int'(if_def.err), 0);
      chk("midrst_velocity", int'(if_def.velocity), 0);
      chk("midrst_vel_valid", int'(if_def.vel_valid), 0);
      chk("midrst_wrap_pos", int'(if_wrap.position), 0);
      repeat (3) @(negedge clk);
      reset_n = 1'b1;
      repeat (3) @(negedge clk);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
`default_nettype wire
